// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: address field widths/slices and the controller state encoding.
package lc3b_types;

  localparam int unsigned TAG_W    = 8;
  localparam int unsigned SET_W    = 4;
  localparam int unsigned NUM_SETS = 16;
  localparam int unsigned NUM_WAYS = 2;
  localparam int unsigned ADDR_W   = 16;

  localparam int unsigned TAG_MSB = 15;
  localparam int unsigned TAG_LSB = 8;
  localparam int unsigned SET_MSB = 7;
  localparam int unsigned SET_LSB = 4;

  typedef logic [TAG_W-1:0]  lc3b_tag;
  typedef logic [SET_W-1:0]  lc3b_set;
  typedef logic [ADDR_W-1:0] lc3b_word;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } cache_state_t;

  function automatic lc3b_tag addr_tag(input lc3b_word addr);
    return addr[TAG_MSB:TAG_LSB];
  endfunction

  function automatic lc3b_set addr_set(input lc3b_word addr);
    return addr[SET_MSB:SET_LSB];
  endfunction

endpackage

// File: rtl/tag_compare.sv
// One-way hit detector: a line matches when it is valid and its stored tag equals the CPU tag.
//   valid    : valid bit of this way for the addressed set
//   line_tag : tag read from the tag array for this way
//   cpu_tag  : tag field of the CPU address
//   match    : this way holds the addressed line
module tag_compare
  import lc3b_types::*;
(
  input  logic    valid,
  input  lc3b_tag line_tag,
  input  lc3b_tag cpu_tag,
  output logic    match
);

  assign match = valid && (line_tag == cpu_tag);

endmodule

// File: rtl/cache_control.sv
// Two-way, 16-set write-back cache controller with zero-wait hits and LRU replacement.
//   clk, reset            : clock and asynchronous active-high reset
//   mem_read/mem_write    : CPU request, held until mem_resp (both high = write)
//   mem_address           : CPU address {tag, set, offset}
//   tag_out0/tag_out1     : tags of the addressed set from the external tag array
//   pmem_resp             : physical memory finished the current line transfer
//   mem_resp, hit, hit_way: CPU completion and hit status
//   way_sel, tag_load, data_load, data_in_sel : tag/data array controls
//   pmem_read, pmem_write, pmem_addr_sel      : physical memory line transfer controls
module cache_control
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     mem_read,
  input  logic     mem_write,
  input  lc3b_word mem_address,
  input  lc3b_tag  tag_out0,
  input  lc3b_tag  tag_out1,
  input  logic     pmem_resp,
  output logic     mem_resp,
  output logic     hit,
  output logic     hit_way,
  output logic     way_sel,
  output logic     tag_load,
  output logic     data_load,
  output logic     data_in_sel,
  output logic     pmem_read,
  output logic     pmem_write,
  output logic     pmem_addr_sel
);

  cache_state_t        state;
  logic [NUM_SETS-1:0] valid [NUM_WAYS];
  logic [NUM_SETS-1:0] dirty [NUM_WAYS];
  logic [NUM_SETS-1:0] lru;
  logic                victim;
  lc3b_set             set_q;

  lc3b_tag cpu_tag;
  lc3b_set cpu_set;
  logic    req;
  logic    hit0;
  logic    hit1;
  logic    unused_offset;

  assign cpu_tag       = addr_tag(mem_address);
  assign cpu_set       = addr_set(mem_address);
  assign req           = mem_read || mem_write;
  assign unused_offset = ^mem_address[SET_LSB-1:0];

  tag_compare u_cmp0 (
    .valid    (valid[0][cpu_set]),
    .line_tag (tag_out0),
    .cpu_tag  (cpu_tag),
    .match    (hit0)
  );

  tag_compare u_cmp1 (
    .valid    (valid[1][cpu_set]),
    .line_tag (tag_out1),
    .cpu_tag  (cpu_tag),
    .match    (hit1)
  );

  assign hit     = hit0 || hit1;
  assign hit_way = hit1;

  // Array/memory controls decoded from state; reset forces IDLE and clears valid, so all read 0
  always_comb begin
    mem_resp      = 1'b0;
    way_sel       = 1'b0;
    tag_load      = 1'b0;
    data_load     = 1'b0;
    data_in_sel   = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    case (state)
      S_IDLE: begin
        if (req && hit) begin
          mem_resp  = 1'b1;
          way_sel   = hit_way;
          data_load = mem_write;
        end
      end
      S_WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim;
      end
      S_ALLOCATE: begin
        pmem_read = 1'b1;
        way_sel   = victim;
        if (pmem_resp) begin
          tag_load    = 1'b1;
          data_load   = 1'b1;
          data_in_sel = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State, per-set metadata and the latched victim/set of an in-flight miss
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      valid  <= '{default: '0};
      dirty  <= '{default: '0};
      lru    <= '0;
      victim <= 1'b0;
      set_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            if (hit) begin
              lru[cpu_set] <= ~hit_way;
              if (mem_write) dirty[hit_way][cpu_set] <= 1'b1;
            end else begin
              victim <= lru[cpu_set];
              set_q  <= cpu_set;
              // Only a valid dirty victim needs writing back before the fill
              if (valid[lru[cpu_set]][cpu_set] && dirty[lru[cpu_set]][cpu_set])
                state <= S_WRITEBACK;
              else
                state <= S_ALLOCATE;
            end
          end
        end
        S_WRITEBACK: begin
          if (pmem_resp) state <= S_ALLOCATE;
        end
        S_ALLOCATE: begin
          if (pmem_resp) begin
            valid[victim][set_q] <= 1'b1;
            dirty[victim][set_q] <= 1'b0;
            state                <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Directed scoreboard bench for cache_control with a behavioural tag array and pmem responder.
module tb_cache_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [7:0]  tag_out0;
  logic [7:0]  tag_out1;
  logic        pmem_resp;
  logic        mem_resp;
  logic        hit;
  logic        hit_way;
  logic        way_sel;
  logic        tag_load;
  logic        data_load;
  logic        data_in_sel;
  logic        pmem_read;
  logic        pmem_write;
  logic        pmem_addr_sel;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       way;
    logic       dl;
    logic       dis;
    logic [7:0] cyc;
  } exp_t;

  typedef struct packed {
    logic       got;
    logic [7:0] cyc;
    logic       way;
    logic       dl;
    logic       dis;
    logic [7:0] wb_cyc;
    logic       wb_sel;
    logic       wb_way;
    logic [7:0] al_cyc;
    logic       al_sel;
    logic       al_way;
    logic       fill;
    logic       both;
    logic       resp_bad;
  } obs_t;

  exp_t sb[$];

  // Tag array has no reset; fill it with a tag that aliases later requests so valid masking matters
  logic [7:0] tarr [2][16] = '{default: 8'h99};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tag_load) tarr[way_sel][mem_address[7:4]] <= mem_address[15:8];
  end

  assign tag_out0 = tarr[0][mem_address[7:4]];
  assign tag_out1 = tarr[1][mem_address[7:4]];

  cache_control dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .tag_out0      (tag_out0),
    .tag_out1      (tag_out1),
    .pmem_resp     (pmem_resp),
    .mem_resp      (mem_resp),
    .hit           (hit),
    .hit_way       (hit_way),
    .way_sel       (way_sel),
    .tag_load      (tag_load),
    .data_load     (data_load),
    .data_in_sel   (data_in_sel),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_addr_sel (pmem_addr_sel)
  );

  // Drives one held request to completion, answering pmem after fixed latencies; records what it saw
  task automatic serve(input logic [15:0] addr, input logic rd, input logic wr,
                       input int wb_lat, input int al_lat, output obs_t o);
    o = '0;
    mem_address = addr;
    mem_read    = rd;
    mem_write   = wr;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (pmem_read && pmem_write) o.both = 1'b1;
      if (pmem_write) begin
        o.wb_cyc = o.wb_cyc + 8'd1;
        o.wb_sel = pmem_addr_sel;
        o.wb_way = way_sel;
        if (int'(o.wb_cyc) == wb_lat) pmem_resp = 1'b1;
      end else if (pmem_read) begin
        o.al_cyc = o.al_cyc + 8'd1;
        o.al_sel = pmem_addr_sel;
        o.al_way = way_sel;
        if (int'(o.al_cyc) == al_lat) begin
          pmem_resp = 1'b1;
          #1 o.fill = tag_load && data_load && data_in_sel && !mem_resp;
        end
      end
      if (mem_resp) begin
        if (pmem_read || pmem_write) o.resp_bad = 1'b1;
        o.got = 1'b1;
        o.cyc = 8'(c);
        o.way = hit_way;
        o.dl  = data_load;
        o.dis = data_in_sel;
        break;
      end
      @(posedge clk);
      #1 pmem_resp = 1'b0;
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] outs;
    reset       = 1'b1;
    mem_read    = 1'b1;
    mem_write   = 1'b0;
    mem_address = 16'h1230;
    pmem_resp   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    outs = {mem_resp, hit, way_sel, tag_load, data_load, data_in_sel,
            pmem_read, pmem_write, pmem_addr_sel};
    n_cmp++;
    if (outs !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want %b", outs, 9'h0);
    end
    mem_read = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_cold_read();
    obs_t o;
    exp_t e;
    sb.push_back('{way: 1'b0, dl: 1'b0, dis: 1'b0, cyc: 8'd3});
    serve(16'h1230, 1'b1, 1'b0, 0, 2, o);
    e = sb.pop_front();
    n_cmp++;
    if (o.got !== 1'b1 || o.cyc !== e.cyc) begin
      n_fail++;
      $display("FAIL cold_latency: got resp=%0b cyc=%0d want resp=1 cyc=%0d", o.got, o.cyc, e.cyc);
    end
    n_cmp++;
    if ({o.al_cyc, o.al_sel, o.al_way, o.wb_cyc} !== {8'd2, 1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL cold_alloc: got al=%0d sel=%0b way=%0b wb=%0d want al=2 sel=0 way=0 wb=0",
               o.al_cyc, o.al_sel, o.al_way, o.wb_cyc);
    end
    n_cmp++;
    if (o.fill !== 1'b1) begin
      n_fail++;
      $display("FAIL cold_fill_strobes: got %0b want 1", o.fill);
    end
    n_cmp++;
    if ({o.way, o.dl} !== {e.way, e.dl}) begin
      n_fail++;
      $display("FAIL cold_hit: got way=%0b dl=%0b want way=%0b dl=%0b", o.way, o.dl, e.way, e.dl);
    end
    n_cmp++;
    if (dut.lru[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL cold_lru: got %0b want 1", dut.lru[3]);
    end
  endtask

  task automatic test_second_way();
    obs_t o;
    exp_t e;
    sb.push_back('{way: 1'b1, dl: 1'b0, dis: 1'b0, cyc: 8'd3});
    serve(16'h5530, 1'b1, 1'b0, 0, 2, o);
    e = sb.pop_front();
    n_cmp++;
    if ({o.got, o.cyc, o.way, o.al_way} !== {1'b1, e.cyc, e.way, 1'b1}) begin
      n_fail++;
      $display("FAIL fill_way1: got resp=%0b cyc=%0d way=%0b alloc_way=%0b want 1 %0d %0b 1",
               o.got, o.cyc, o.way, o.al_way, e.cyc, e.way);
    end
    // Back-to-back hits on both resident lines, each zero-wait
    sb.push_back('{way: 1'b0, dl: 1'b0, dis: 1'b0, cyc: 8'd0});
    sb.push_back('{way: 1'b1, dl: 1'b0, dis: 1'b0, cyc: 8'd0});
    for (int i = 0; i < 2; i++) begin
      serve((i == 0) ? 16'h1230 : 16'h5530, 1'b1, 1'b0, 0, 2, o);
      e = sb.pop_front();
      n_cmp++;
      if ({o.got, o.cyc, o.way, o.al_cyc} !== {1'b1, e.cyc, e.way, 8'd0}) begin
        n_fail++;
        $display("FAIL hit_%0d: got resp=%0b cyc=%0d way=%0b al=%0d want 1 %0d %0b 0",
                 i, o.got, o.cyc, o.way, o.al_cyc, e.cyc, e.way);
      end
    end
  endtask

  task automatic test_write_hit();
    obs_t o;
    exp_t e;
    sb.push_back('{way: 1'b0, dl: 1'b1, dis: 1'b0, cyc: 8'd0});
    serve(16'h1230, 1'b0, 1'b1, 0, 2, o);
    e = sb.pop_front();
    n_cmp++;
    if ({o.got, o.cyc, o.way, o.dl, o.dis} !== {1'b1, e.cyc, e.way, e.dl, e.dis}) begin
      n_fail++;
      $display("FAIL write_hit: got resp=%0b cyc=%0d way=%0b dl=%0b dis=%0b want 1 0 0 1 0",
               o.got, o.cyc, o.way, o.dl, o.dis);
    end
    n_cmp++;
    if (dut.dirty[0][3] !== 1'b1) begin
      n_fail++;
      $display("FAIL write_dirty: got %0b want 1", dut.dirty[0][3]);
    end
  endtask

  task automatic test_writeback();
    obs_t o;
    exp_t e;
    // Touch way 1 so way 0 (dirty) becomes the victim
    sb.push_back('{way: 1'b1, dl: 1'b0, dis: 1'b0, cyc: 8'd0});
    serve(16'h5530, 1'b1, 1'b0, 0, 2, o);
    e = sb.pop_front();
    n_cmp++;
    if ({o.got, o.way, dut.lru[3]} !== {1'b1, e.way, 1'b0}) begin
      n_fail++;
      $display("FAIL pre_wb_hit: got resp=%0b way=%0b lru=%0b want 1 1 0", o.got, o.way, dut.lru[3]);
    end
    sb.push_back('{way: 1'b0, dl: 1'b0, dis: 1'b0, cyc: 8'd6});
    serve(16'h7730, 1'b1, 1'b0, 3, 2, o);
    e = sb.pop_front();
    n_cmp++;
    if ({o.wb_cyc, o.wb_sel, o.wb_way} !== {8'd3, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wb_phase: got cyc=%0d sel=%0b way=%0b want 3 1 0", o.wb_cyc, o.wb_sel, o.wb_way);
    end
    n_cmp++;
    if ({o.al_cyc, o.al_sel, o.al_way, o.fill} !== {8'd2, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL wb_alloc: got cyc=%0d sel=%0b way=%0b fill=%0b want 2 0 0 1",
               o.al_cyc, o.al_sel, o.al_way, o.fill);
    end
    n_cmp++;
    if ({o.got, o.cyc, o.way, o.both, o.resp_bad} !== {1'b1, e.cyc, e.way, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL wb_resp: got resp=%0b cyc=%0d way=%0b both=%0b bad=%0b want 1 %0d 0 0 0",
               o.got, o.cyc, o.way, o.both, o.resp_bad, e.cyc);
    end
    n_cmp++;
    if (dut.dirty[0][3] !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_dirty_clear: got %0b want 0", dut.dirty[0][3]);
    end
  endtask

  task automatic test_read_write_both();
    obs_t o;
    exp_t e;
    sb.push_back('{way: 1'b1, dl: 1'b1, dis: 1'b0, cyc: 8'd0});
    serve(16'h5530, 1'b1, 1'b1, 0, 2, o);
    e = sb.pop_front();
    n_cmp++;
    if ({o.got, o.cyc, o.way, o.dl, o.dis} !== {1'b1, e.cyc, e.way, e.dl, e.dis}) begin
      n_fail++;
      $display("FAIL rw_both: got resp=%0b cyc=%0d way=%0b dl=%0b dis=%0b want 1 0 1 1 0",
               o.got, o.cyc, o.way, o.dl, o.dis);
    end
    n_cmp++;
    if (dut.dirty[1][3] !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_both_dirty: got %0b want 1", dut.dirty[1][3]);
    end
  endtask

  task automatic test_reset_in_allocate();
    obs_t o;
    exp_t e;
    mem_address = 16'h9940;
    mem_read    = 1'b1;
    mem_write   = 1'b0;
    #1;
    n_cmp++;
    if ({mem_resp, hit} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_first_miss: got resp=%0b hit=%0b want 0 0", mem_resp, hit);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (pmem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_alloc_entry: got pmem_read=%0b want 1", pmem_read);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({pmem_read, pmem_write, tag_load, data_load, mem_resp} !== 5'b0) begin
      n_fail++;
      $display("FAIL abort_strobes: got rd=%0b wr=%0b tl=%0b dl=%0b resp=%0b want all 0",
               pmem_read, pmem_write, tag_load, data_load, mem_resp);
    end
    @(posedge clk);
    #3 reset = 1'b0;
    // Stale tag 0x99 is still in the array but the line must read as invalid
    sb.push_back('{way: 1'b0, dl: 1'b0, dis: 1'b0, cyc: 8'd3});
    serve(16'h9940, 1'b1, 1'b0, 0, 2, o);
    e = sb.pop_front();
    n_cmp++;
    if ({o.got, o.cyc, o.al_cyc, o.way} !== {1'b1, e.cyc, 8'd2, e.way}) begin
      n_fail++;
      $display("FAIL abort_refetch: got resp=%0b cyc=%0d al=%0d way=%0b want 1 %0d 2 0",
               o.got, o.cyc, o.al_cyc, o.way, e.cyc);
    end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_second_way();
    test_write_hit();
    test_writeback();
    test_read_write_both();
    test_reset_in_allocate();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 The block SHALL have no parameters; all widths come from lc3b_types (lc3b_tag = 8 bits, lc3b_set = 4 bits, 16 sets, 2 ways).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous active-high reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_address  in  16  CPU address: tag = [15:8], set = [7:4], offset = [3:0]
- tag_out0  in  8  way-0 tag of the addressed set, from the tag array
- tag_out1  in  8  way-1 tag of the addressed set, from the tag array
- pmem_resp  in  1  physical memory has completed the current line transfer
- mem_resp  out  1  CPU request complete this cycle
- hit  out  1  the addressed line is resident
- hit_way  out  1  the way that hit
- way_sel  out  1  way driven to the tag-array and data-array way select
- tag_load  out  1  tag-array write enable
- data_load  out  1  data-array write enable
- data_in_sel  out  1  data-array write source: 0 = CPU merge, 1 = pmem line
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_addr_sel  out  1  pmem address source: 0 = {CPU tag, set, 4'h0}; 1 = {victim tag, set, 4'h0}

Function
REQ-004 The block SHALL hold per-set state internally: valid[2][16], dirty[2][16] and lru[16], where lru = the way to replace next.
REQ-005 The block SHALL compute hit combinationally: way-n hits when valid[n][set] is set and tag_out_n equals the tag; hit = OR of both ways; hit_way = 1 only when way 1 hits.
REQ-006 The FSM SHALL have three states: IDLE, WRITEBACK and ALLOCATE.
REQ-007 In IDLE with a request and a hit, the block SHALL assert mem_resp in the same cycle (zero-wait hit) and drive way_sel = hit_way.
REQ-008 On the posedge that ends a hit, the block SHALL set lru[set] to the inverse of hit_way.
REQ-009 On a write hit, the block SHALL also assert data_load with data_in_sel = 0 and set dirty[hit_way][set] on the posedge.
REQ-010 In IDLE with a request and a miss, the victim SHALL be v = lru[set]. If valid[v][set] and dirty[v][set] are both set, the next state SHALL be WRITEBACK; otherwise ALLOCATE.
REQ-011 WRITEBACK SHALL drive pmem_write = 1, pmem_addr_sel = 1 and way_sel = v. It SHALL hold until pmem_resp, then go to ALLOCATE.
REQ-012 ALLOCATE SHALL drive pmem_read = 1, pmem_addr_sel = 0 and way_sel = v.
REQ-013 In ALLOCATE, on pmem_resp the block SHALL assert tag_load and data_load (data_in_sel = 1) for one cycle, set valid[v][set], clear dirty[v][set], and return to IDLE.
REQ-014 After a fill, the request SHALL be re-evaluated in IDLE. It then hits one cycle later, and a write then merges through REQ-009.
REQ-015 mem_resp SHALL never be asserted outside IDLE, and never on a miss.
REQ-016 The victim v SHALL be latched on entry to WRITEBACK or ALLOCATE and held until the fill completes.
REQ-017 If mem_read and mem_write are both high, the block SHALL treat the request as a write.
REQ-018 Once a miss has started, deassertion of the request SHALL NOT abort it; the fill completes and no mem_resp is issued unless a request is present in IDLE.
REQ-019 pmem_read and pmem_write SHALL never be asserted together.
REQ-020 In every output state not listed above, each output SHALL be 0.

Reset
REQ-021 Reset SHALL force the state to IDLE and clear all of valid, dirty and lru.
REQ-022 While reset is asserted, every output except hit and hit_way SHALL be 0; hit SHALL read 0 because all valid bits are clear.
REQ-023 Reset during WRITEBACK or ALLOCATE SHALL drop the pmem strobes immediately; the aborted line is invalid.
REQ-024 The tag array has no reset of its own; cleared valid bits SHALL mask its contents.

Structure
REQ-025 lc3b_tag, lc3b_set, the state enum and the address-field slice positions SHALL live in lc3b_types.
REQ-026 The FSM and the per-set valid/dirty/lru registers SHALL live in one module.
REQ-027 The hit comparator SHALL be one sub-module, tag_compare, instantiated once per way.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Cold read after reset at 0x1230: miss; ALLOCATE with pmem_addr_sel = 0 and way_sel = 0; on pmem_resp, tag_load = data_load = 1; the next cycle mem_resp = 1, hit_way = 0, lru[3] = 1.
- Read 0x5530 after the first scenario: fills way 1; then reads of 0x1230 and 0x5530 each hit with a single-cycle mem_resp.
- Write hit to 0x1230: the same cycle gives mem_resp = 1, data_load = 1, data_in_sel = 0; dirty[0][3] = 1.
- Read 0x7730 with way 0 dirty and lru[3] = 0: WRITEBACK (pmem_write = 1, pmem_addr_sel = 1) for 3 cycles until pmem_resp, then ALLOCATE, then a hit; dirty[0][3] = 0.
- Reset asserted in the second cycle of ALLOCATE: pmem_read = 0 asynchronously; a following read of the same address misses.
- mem_read and mem_write both high on a hit: treated as a write (data_load = 1, dirty set).
